// File: rtl/booth_arbiter.sv
// booth_arbiter
//   Shares one voting_machine core between NUM_BOOTHS booths. The core is
//   granted round-robin to one booth at a time, and each session is run as
//   ID check -> vote issue -> wait for done. The booth gets an accept or a
//   reject pulse at the end, and session/reject statistics are kept.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   booth_req/id/vote/cand  per-booth request level, packed IDs, vote strobe, choice
//   grant                 one-hot session owner (zero when idle)
//   booth_ack/reject      one-cycle result pulses to the owner
//   reject_code           01 invalid ID, 10 ID used, 11 timeout (valid with reject)
//   core_*                handshake with the voting_machine core
//   sessions/rejects      saturating 8-bit statistics
//   busy                  high whenever a session is in progress
module booth_arbiter #(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BOOTHS-1:0]      booth_req,
  input  logic [NUM_BOOTHS*ID_W-1:0] booth_id,
  input  logic [NUM_BOOTHS-1:0]      booth_vote,
  input  logic [NUM_BOOTHS-1:0]      booth_cand,
  output logic [NUM_BOOTHS-1:0]      grant,
  output logic [NUM_BOOTHS-1:0]      booth_ack,
  output logic [NUM_BOOTHS-1:0]      booth_reject,
  output logic [1:0]                 reject_code,
  output logic [ID_W-1:0]            core_id,
  output logic                       core_check,
  output logic                       core_vote_signal,
  output logic                       core_candidate_select,
  input  logic                       core_id_valid,
  input  logic                       core_id_used,
  input  logic                       core_vote_done,
  output logic [7:0]                 sessions,
  output logic [7:0]                 rejects,
  output logic                       busy
);

  localparam int unsigned OW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;

  localparam logic [1:0] CODE_INVALID = 2'b01;
  localparam logic [1:0] CODE_USED    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_ID,
    WAIT_VOTE,
    WAIT_DONE,
    ACK,
    REJECT
  } state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   last, last_nxt;
  logic [ID_W-1:0] id_q, id_nxt;
  logic [1:0]      code_q, code_nxt;
  logic [7:0]      tmo_q, tmo_nxt;
  logic [7:0]      sess_q, rej_q;

  logic [OW-1:0]         pick;
  logic                  pick_found;
  int unsigned           scan_idx;
  logic [OW-1:0]         scan_sel;
  logic [NUM_BOOTHS-1:0] owner_oh;
  logic                  owner_req;
  logic                  owner_vote;
  logic                  tmo_last;

  // Round-robin search starting one past the last session owner.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = 0;
    scan_sel   = '0;
    for (int unsigned i = 1; i <= NUM_BOOTHS; i++) begin
      scan_idx = (32'(last) + i) % NUM_BOOTHS;
      scan_sel = OW'(scan_idx);
      if (!pick_found && booth_req[scan_sel]) begin
        pick       = scan_sel;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  assign owner_req  = booth_req[owner];
  assign owner_vote = booth_vote[owner];
  // Counter is cleared on entry, so this is the TIMEOUT-th waiting cycle.
  assign tmo_last   = (tmo_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    id_nxt    = id_q;
    code_nxt  = code_q;
    tmo_nxt   = tmo_q;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nxt = pick;
          id_nxt    = booth_id[32'(pick)*ID_W +: ID_W];
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!owner_req) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (!owner_req) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (!core_id_valid) begin
          code_nxt  = CODE_INVALID;
          state_nxt = REJECT;
        end else if (core_id_used) begin
          code_nxt  = CODE_USED;
          state_nxt = REJECT;
        end else begin
          tmo_nxt   = '0;
          state_nxt = WAIT_VOTE;
        end
      end
      WAIT_VOTE: begin
        // A dropped request wins over a same-cycle vote: nothing reaches the core.
        if (!owner_req) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (owner_vote) begin
          tmo_nxt   = '0;
          state_nxt = WAIT_DONE;
        end else if (tmo_last) begin
          code_nxt  = CODE_TIMEOUT;
          state_nxt = REJECT;
        end else begin
          tmo_nxt = tmo_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        // Request level is ignored here: the vote is already with the core.
        if (core_vote_done) begin
          state_nxt = ACK;
        end else if (tmo_last) begin
          code_nxt  = CODE_TIMEOUT;
          state_nxt = REJECT;
        end else begin
          tmo_nxt = tmo_q + 8'd1;
        end
      end
      ACK, REJECT: begin
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= OW'(NUM_BOOTHS - 1);
      id_q   <= '0;
      code_q <= '0;
      tmo_q  <= '0;
      sess_q <= '0;
      rej_q  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      id_q   <= id_nxt;
      code_q <= code_nxt;
      tmo_q  <= tmo_nxt;
      if (state == ACK && sess_q != 8'hFF) begin
        sess_q <= sess_q + 8'd1;
      end
      if (state == REJECT && rej_q != 8'hFF) begin
        rej_q <= rej_q + 8'd1;
      end
    end
  end

  always_comb begin
    busy                  = (state != IDLE);
    grant                 = busy ? owner_oh : '0;
    booth_ack             = (state == ACK) ? owner_oh : '0;
    booth_reject          = (state == REJECT) ? owner_oh : '0;
    reject_code           = (state == REJECT) ? code_q : 2'b00;
    core_id               = id_q;
    core_check            = (state == CHECK);
    core_vote_signal      = (state == WAIT_VOTE) && owner_req && owner_vote;
    core_candidate_select = core_vote_signal && booth_cand[owner];
    sessions              = sess_q;
    rejects               = rej_q;
  end

endmodule

// File: tb/tb_booth_arbiter.sv
module tb_booth_arbiter;

  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] booth_req;
  logic [NB*4-1:0] booth_id;
  logic [NB-1:0] booth_vote;
  logic [NB-1:0] booth_cand;
  logic [NB-1:0] grant;
  logic [NB-1:0] booth_ack;
  logic [NB-1:0] booth_reject;
  logic [1:0]    reject_code;
  logic [3:0]    core_id;
  logic          core_check;
  logic          core_vote_signal;
  logic          core_candidate_select;
  logic          core_id_valid;
  logic          core_id_used;
  logic          core_vote_done;
  logic [7:0]    sessions;
  logic [7:0]    rejects;
  logic          busy;

  booth_arbiter #(
    .NUM_BOOTHS(NB),
    .ID_W(4),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .booth_req(booth_req),
    .booth_id(booth_id),
    .booth_vote(booth_vote),
    .booth_cand(booth_cand),
    .grant(grant),
    .booth_ack(booth_ack),
    .booth_reject(booth_reject),
    .reject_code(reject_code),
    .core_id(core_id),
    .core_check(core_check),
    .core_vote_signal(core_vote_signal),
    .core_candidate_select(core_candidate_select),
    .core_id_valid(core_id_valid),
    .core_id_used(core_id_used),
    .core_vote_done(core_vote_done),
    .sessions(sessions),
    .rejects(rejects),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int unsigned NEVER = 255;

  typedef enum int unsigned {EV_CHECK, EV_VOTE, EV_ACK, EV_REJ} ev_t;

  typedef struct {
    ev_t         kind;
    int unsigned booth;
    logic [1:0]  code;
    logic [3:0]  id;
    logic        cand;
  } ev_s;

  typedef struct {
    int unsigned booth;
    logic [3:0]  id;
    logic        valid;
    logic        used;
    logic        cand;
    int unsigned vote_dly;
    int unsigned done_dly;
    logic        noise;
    logic        drop_done;
    logic        exp_ack;
    logic [1:0]  exp_code;
    logic        exp_vote;
  } vec_t;

  ev_s         sb[$];
  vec_t        vecs[8];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned exp_sess = 0;
  int unsigned exp_rej = 0;
  int unsigned rr_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NB-1:0] oh(input int unsigned b);
    logic [NB-1:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  // Scoreboard consumer: every core strobe and every result pulse pops one event.
  always @(negedge clk) begin : monitor
    ev_s         e;
    int unsigned act;
    if (!reset && (core_check || core_vote_signal || booth_ack != '0 || booth_reject != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {core_check, core_vote_signal, booth_ack, booth_reject}, 0);
      end else begin
        e = sb.pop_front();
        act = core_check ? EV_CHECK : core_vote_signal ? EV_VOTE :
              (booth_ack != '0) ? EV_ACK : EV_REJ;
        chk("event_kind", act, e.kind);
        case (e.kind)
          EV_CHECK: begin
            chk("check_core_id", core_id, e.id);
            chk("check_grant", grant, oh(e.booth));
          end
          EV_VOTE: begin
            chk("vote_cand", core_candidate_select, e.cand);
            chk("vote_core_id", core_id, e.id);
            chk("vote_no_check", core_check, 0);
          end
          EV_ACK: chk("ack_onehot", booth_ack, oh(e.booth));
          default: begin
            chk("reject_onehot", booth_reject, oh(e.booth));
            chk("reject_code", reject_code, e.code);
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_check();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_check && n < 20);
    chk("check_seen", core_check, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned   n;
    logic [NB-1:0] m;
    m = oh(v.booth);
    sb.push_back('{EV_CHECK, v.booth, 2'b00, v.id, 1'b0});
    if (v.exp_vote) sb.push_back('{EV_VOTE, v.booth, 2'b00, v.id, v.cand});
    sb.push_back('{v.exp_ack ? EV_ACK : EV_REJ, v.booth, v.exp_code, v.id, 1'b0});
    core_id_valid = v.valid;
    core_id_used  = v.used;
    booth_id[v.booth*4 +: 4] = v.id;
    booth_cand = v.cand ? '1 : '0;
    if (v.noise) booth_vote = ~m;
    booth_req = m;
    wait_check();
    tick();  // WAIT_ID
    if (v.valid && !v.used && v.vote_dly != NEVER) begin
      tick();  // first WAIT_VOTE cycle
      repeat (v.vote_dly) tick();
      booth_vote = m;
      tick();  // first WAIT_DONE cycle
      booth_vote = '0;
      if (v.drop_done) booth_req = '0;
      if (v.done_dly != NEVER) begin
        repeat (v.done_dly) tick();
        core_vote_done = 1'b1;
        tick();
        core_vote_done = 1'b0;
      end
    end
    n = 0;
    while (booth_ack == '0 && booth_reject == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("end_seen", (booth_ack | booth_reject) != '0, 1);
    tick();
    booth_req = '0;
    booth_vote = '0;
    core_vote_done = 1'b0;
    if (v.exp_ack) exp_sess++;
    else exp_rej++;
    tick();
    chk("sessions", sessions, exp_sess);
    chk("rejects", rejects, exp_rej);
  endtask

  // All booths request; every session completes (ok) or fails ID check at once.
  task automatic run_rr(input int unsigned cnt, input logic ok);
    int unsigned b;
    int unsigned n;
    core_id_valid = ok;
    core_id_used  = 1'b0;
    booth_id      = {4'hD, 4'hC, 4'hB, 4'hA};
    booth_cand    = 4'b0101;
    booth_req     = '1;
    for (int unsigned k = 0; k < cnt; k++) begin
      b = rr_k % NB;
      sb.push_back('{EV_CHECK, b, 2'b00, 4'(4'hA + b), 1'b0});
      if (ok) begin
        sb.push_back('{EV_VOTE, b, 2'b00, 4'(4'hA + b), (b % 2) == 0});
        sb.push_back('{EV_ACK, b, 2'b00, 4'(4'hA + b), 1'b0});
      end else begin
        sb.push_back('{EV_REJ, b, 2'b01, 4'(4'hA + b), 1'b0});
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (grant == '0 && n < 10);
      chk("rr_grant", grant, oh(b));
      tick();  // WAIT_ID
      tick();  // WAIT_VOTE or REJECT
      if (ok) begin
        booth_vote = '1;  // non-owner strobes must be ignored
        tick();
        booth_vote = '0;
        core_vote_done = 1'b1;
        tick();  // ACK
        core_vote_done = 1'b0;
      end
      tick();  // IDLE gap
      if (k == cnt - 1) booth_req = '0;
      chk("rr_idle_gap", {busy, grant}, 0);
      if (ok) exp_sess = (exp_sess < 255) ? exp_sess + 1 : 255;
      else exp_rej = (exp_rej < 255) ? exp_rej + 1 : 255;
      rr_k++;
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            booth id    vld   used  cand  vdly   ddly   noise drop  ack   code   vote
    vecs[0] = '{1, 4'h5, 1'b1, 1'b0, 1'b1, 0,     0,     1'b0, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[1] = '{2, 4'h3, 1'b0, 1'b0, 1'b0, 0,     0,     1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[2] = '{0, 4'h7, 1'b1, 1'b1, 1'b0, 0,     0,     1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
    vecs[3] = '{3, 4'h9, 1'b1, 1'b0, 1'b0, NEVER, 0,     1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
    vecs[4] = '{1, 4'h2, 1'b1, 1'b0, 1'b1, 0,     NEVER, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};
    vecs[5] = '{2, 4'h6, 1'b1, 1'b0, 1'b0, 14,    14,    1'b0, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[6] = '{3, 4'h8, 1'b1, 1'b0, 1'b1, 2,     1,     1'b0, 1'b1, 1'b1, 2'b00, 1'b1};
    vecs[7] = '{0, 4'hF, 1'b0, 1'b1, 1'b0, 0,     0,     1'b0, 1'b0, 1'b0, 2'b01, 1'b0};

    reset = 1'b1;
    booth_req = '0;
    booth_id = '0;
    booth_vote = '0;
    booth_cand = '0;
    core_id_valid = 1'b0;
    core_id_used = 1'b0;
    core_vote_done = 1'b0;
    #13;
    chk("reset_outputs", {grant, booth_ack, booth_reject, reject_code, core_check,
                          core_vote_signal, busy}, 0);
    chk("reset_counters", {sessions, rejects}, 0);
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Request dropped in WAIT_VOTE: abort, no vote, no pulses, counters kept.
    sb.push_back('{EV_CHECK, 2, 2'b00, 4'h1, 1'b0});
    core_id_valid = 1'b1;
    core_id_used = 1'b0;
    booth_id[8 +: 4] = 4'h1;
    booth_req = oh(2);
    wait_check();
    tick();
    tick();
    booth_req = '0;
    booth_vote = oh(2);
    tick();
    booth_vote = '0;
    chk("abort_idle", {busy, grant}, 0);
    repeat (3) tick();
    chk("abort_sessions", sessions, exp_sess);
    chk("abort_rejects", rejects, exp_rej);

    // Async reset while waiting for the core to finish.
    sb.push_back('{EV_CHECK, 0, 2'b00, 4'h4, 1'b0});
    sb.push_back('{EV_VOTE, 0, 2'b00, 4'h4, 1'b1});
    booth_id[0 +: 4] = 4'h4;
    booth_cand = '1;
    booth_req = oh(0);
    wait_check();
    tick();
    tick();
    booth_vote = oh(0);
    tick();
    booth_vote = '0;
    tick();
    #1;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {grant, booth_ack, booth_reject, reject_code, core_check,
                                core_vote_signal, busy}, 0);
    chk("async_reset_counters", {sessions, rejects}, 0);
    chk("async_reset_core_id", core_id, 0);
    sb.delete();
    booth_req = '0;
    tick();
    reset = 1'b0;
    exp_sess = 0;
    exp_rej = 0;
    tick();

    // Round-robin from reset: 0001, 0010, 0100, 1000, 0001.
    run_rr(5, 1'b1);
    chk("rr_sessions", sessions, 5);
    run_rr(255, 1'b1);
    chk("sessions_saturate", sessions, 255);
    run_rr(260, 1'b0);
    chk("rejects_saturate", rejects, 255);
    chk("sessions_hold", sessions, exp_sess);

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
